// File: rtl/clkgen_pkg.sv
// rtl/clkgen_pkg.sv - shared sequencer state encoding and lock-counter width helper
package clkgen_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_HOLD = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_RUN  = 2'd2;

    function automatic int lock_cnt_w(input int lock_wait);
        return $clog2(lock_wait);
    endfunction

endpackage

// File: rtl/clkdiv_ch.sv
// rtl/clkdiv_ch.sv - one clock-enable divider channel with optional freeze/forced-pulse hooks
module clkdiv_ch
    import clkgen_pkg::*;
#(
    parameter int DIVW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic            hold,
    input  logic            pulse,
    input  logic [DIVW-1:0] div,
    output logic            ce,
    output logic [DIVW-1:0] cnt
);

    // run is the sequencer's next-state view, so ce drops in the same cycle sys_rst_n does
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            ce  <= 1'b0;
        end else if (!run) begin
            cnt <= '0;
            ce  <= 1'b0;
        end else if (hold) begin
            ce  <= pulse;
        end else if (cnt >= div) begin
            cnt <= '0;
            ce  <= 1'b1;
        end else begin
            cnt <= cnt + DIVW'(1);
            ce  <= 1'b0;
        end
    end

endmodule

// File: rtl/clken_gen.sv
// rtl/clken_gen.sv - PLL-lock reset sequencer and NCH clock-enable generator; CLKGEN_STEP_EN adds channel 0 single-step
module clken_gen
    import clkgen_pkg::*;
#(
    parameter int NCH       = 2,
    parameter int DIVW      = 16,
    parameter int LOCK_WAIT = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pll_lock,
    input  logic [NCH*DIVW-1:0] div,
    input  logic                step_mode,
    input  logic                step,
    output logic                sys_rst_n,
    output logic [NCH-1:0]      ce,
    output logic                running
);

    localparam int LCW = lock_cnt_w(LOCK_WAIT);

    logic           lock_s1;
    logic           lock_s;
    state_t         state;
    state_t         state_nxt;
    logic [LCW-1:0] lock_cnt;
    logic           run_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_HOLD: if (lock_s) state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (!lock_s)
                    state_nxt = ST_HOLD;
                else if (lock_cnt == LCW'(LOCK_WAIT - 1))
                    state_nxt = ST_RUN;
            end
            ST_RUN:  if (!lock_s) state_nxt = ST_HOLD;
            default: state_nxt = ST_HOLD;
        endcase
    end

    assign run_nxt = (state_nxt == ST_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_s1   <= 1'b0;
            lock_s    <= 1'b0;
            state     <= ST_HOLD;
            lock_cnt  <= '0;
            sys_rst_n <= 1'b0;
            running   <= 1'b0;
        end else begin
            lock_s1   <= pll_lock;
            lock_s    <= lock_s1;
            state     <= state_nxt;
            // counter only survives while staying in WAIT; any exit or glitch restarts it
            lock_cnt  <= (state == ST_WAIT && state_nxt == ST_WAIT) ? lock_cnt + LCW'(1) : '0;
            sys_rst_n <= run_nxt;
            running   <= run_nxt;
        end
    end

    logic step_hold;
    logic step_pulse;

`ifdef CLKGEN_STEP_EN
    logic step_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            step_q <= 1'b0;
        else
            step_q <= step;
    end

    assign step_hold  = step_mode;
    assign step_pulse = step & ~step_q;
`else
    assign step_hold  = 1'b0;
    assign step_pulse = 1'b0;
    wire unused_step = &{1'b0, step, step_mode};
`endif

    logic [NCH-1:0]           hold_v;
    logic [NCH-1:0]           pulse_v;
    logic [NCH-1:0][DIVW-1:0] cnt_v;

    always_comb begin
        hold_v     = '0;
        pulse_v    = '0;
        hold_v[0]  = step_hold;
        pulse_v[0] = step_pulse;
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        clkdiv_ch #(
            .DIVW (DIVW)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .run   (run_nxt),
            .hold  (hold_v[g]),
            .pulse (pulse_v[g]),
            .div   (div[g*DIVW +: DIVW]),
            .ce    (ce[g]),
            .cnt   (cnt_v[g])
        );
    end

    wire unused_cnt = &{1'b0, cnt_v};

endmodule

// File: tb/tb_clken_gen.sv
// tb/tb_clken_gen.sv - directed table-driven bench for clken_gen (NCH=2, DIVW=8, LOCK_WAIT=16)
module tb_clken_gen;

    localparam int NCH       = 2;
    localparam int DIVW      = 8;
    localparam int LOCK_WAIT = 16;

    logic                clk;
    logic                rst_n;
    logic                pll_lock;
    logic [NCH*DIVW-1:0] div;
    logic                step_mode;
    logic                step;
    logic                sys_rst_n;
    logic [NCH-1:0]      ce;
    logic                running;

    int n_checks = 0;
    int n_fail   = 0;

    clken_gen #(
        .NCH       (NCH),
        .DIVW      (DIVW),
        .LOCK_WAIT (LOCK_WAIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pll_lock  (pll_lock),
        .div       (div),
        .step_mode (step_mode),
        .step      (step),
        .sys_rst_n (sys_rst_n),
        .ce        (ce),
        .running   (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DIVW-1:0] div0;
        logic [DIVW-1:0] div1;
        logic [1:0]      exp_ce;
    } vec_t;

    vec_t tbl [22];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_div(input logic [DIVW-1:0] d0, input logic [DIVW-1:0] d1);
        div = {d1, d0};
    endtask

    // release lands on the n-th edge; with div0=0, div1=3 only ce[0] fires on that edge
    task automatic expect_release(input int n, input string tag);
        for (int k = 1; k <= n; k++) begin
            tick();
            check({tag, " sys_rst_n"}, 32'(sys_rst_n), 32'(k == n));
            check({tag, " running"},   32'(running),   32'(k == n));
            check({tag, " ce"},        32'(ce),        (k == n) ? 32'h1 : 32'h0);
        end
    endtask

    function automatic logic step_pat(input int i);
        return (i == 3) || (i >= 10 && i <= 19) || (i == 25 || i == 26);
    endfunction

    initial begin
        int ce0_cnt;
        int ce1_cnt;
        logic exp0;

        tbl[0]  = '{8'd0, 8'd3, 2'b01};
        tbl[1]  = '{8'd0, 8'd3, 2'b01};
        tbl[2]  = '{8'd0, 8'd3, 2'b11};
        tbl[3]  = '{8'd0, 8'd3, 2'b01};
        tbl[4]  = '{8'd0, 8'd3, 2'b01};
        tbl[5]  = '{8'd0, 8'd3, 2'b01};
        tbl[6]  = '{8'd0, 8'd3, 2'b11};
        tbl[7]  = '{8'd0, 8'd9, 2'b01};
        tbl[8]  = '{8'd0, 8'd9, 2'b01};
        tbl[9]  = '{8'd0, 8'd9, 2'b01};
        tbl[10] = '{8'd0, 8'd9, 2'b01};
        tbl[11] = '{8'd0, 8'd9, 2'b01};
        tbl[12] = '{8'd0, 8'd2, 2'b11};
        tbl[13] = '{8'd0, 8'd2, 2'b01};
        tbl[14] = '{8'd0, 8'd2, 2'b01};
        tbl[15] = '{8'd0, 8'd2, 2'b11};
        tbl[16] = '{8'd0, 8'd2, 2'b01};
        tbl[17] = '{8'd0, 8'd2, 2'b01};
        tbl[18] = '{8'd0, 8'd2, 2'b11};
        tbl[19] = '{8'd2, 8'd2, 2'b00};
        tbl[20] = '{8'd2, 8'd2, 2'b00};
        tbl[21] = '{8'd2, 8'd2, 2'b11};

        rst_n     = 1'b0;
        pll_lock  = 1'b1;
        step_mode = 1'b0;
        step      = 1'b0;
        set_div(8'd0, 8'd3);

        tick();
        tick();
        check("reset sys_rst_n", 32'(sys_rst_n), 32'h0);
        check("reset running",   32'(running),   32'h0);
        check("reset ce",        32'(ce),        32'h0);

        rst_n = 1'b1;
        expect_release(19, "release");

        for (int r = 0; r < 22; r++) begin
            set_div(tbl[r].div0, tbl[r].div1);
            tick();
            check($sformatf("div row %0d ce", r), 32'(ce), 32'(tbl[r].exp_ce));
            check($sformatf("div row %0d sys_rst_n", r), 32'(sys_rst_n), 32'h1);
        end

        // step window: div0=5, div1=3, step toggled in three bursts (one held 10 cycles)
        ce0_cnt   = 0;
        ce1_cnt   = 0;
        step_mode = 1'b1;
        set_div(8'd5, 8'd3);
        for (int i = 0; i < 40; i++) begin
            step = step_pat(i);
            tick();
`ifdef CLKGEN_STEP_EN
            exp0 = step_pat(i) && !(i > 0 && step_pat(i - 1));
`else
            exp0 = (i % 6) == 5;
`endif
            check($sformatf("step win %0d ce0", i), 32'(ce[0]), 32'(exp0));
            ce0_cnt += int'(ce[0]);
            ce1_cnt += int'(ce[1]);
        end
        step = 1'b0;
`ifdef CLKGEN_STEP_EN
        check("step ce0 pulse count", 32'(ce0_cnt), 32'd3);
`else
        check("step ce0 pulse count", 32'(ce0_cnt), 32'd6);
`endif
        check("step ce1 pulse count", 32'(ce1_cnt), 32'd10);

        step_mode = 1'b0;
`ifdef CLKGEN_STEP_EN
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("step resume %0d ce0", k), 32'(ce[0]), 32'(k == 6));
        end
`endif

        // lock loss in RUN: outputs fall on the third edge
        set_div(8'd0, 8'd3);
        pll_lock = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("lock loss %0d sys_rst_n", k), 32'(sys_rst_n), 32'(k < 3));
            check($sformatf("lock loss %0d running", k),   32'(running),   32'(k < 3));
            check($sformatf("lock loss %0d ce0", k),       32'(ce[0]),     32'(k < 3));
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            check("lock lost ce", 32'(ce), 32'h0);
        end
        pll_lock = 1'b1;
        expect_release(19, "relock");

        // asynchronous reset between edges
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        check("async rst sys_rst_n", 32'(sys_rst_n), 32'h0);
        check("async rst running",   32'(running),   32'h0);
        check("async rst ce",        32'(ce),        32'h0);
        rst_n = 1'b1;

        // one-cycle lock glitch while WAIT counter is near 10
        for (int k = 0; k < 11; k++) begin
            tick();
            check("glitch pre sys_rst_n", 32'(sys_rst_n), 32'h0);
        end
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        expect_release(19, "glitch");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
